// File: rtl/mac_reg_pkg.sv
// Shared constants, state encoding and decode helper for the MAC register bus bridge.
package mac_reg_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned OFF_W    = 5;
   localparam int unsigned NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] BASE_ADDR = 32'hFFFF_FA40;
   localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(NUM_REGS) - 32'd1;

   // Readable offsets: 0x00, 0x01 and the result block 0x12..0x1F
   localparam logic [OFF_W-1:0] RD_LO0   = 5'h00;
   localparam logic [OFF_W-1:0] RD_LO1   = 5'h01;
   localparam logic [OFF_W-1:0] RD_HI_LO = 5'h12;
   localparam logic [OFF_W-1:0] RD_HI_HI = 5'h1F;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Upper bound RD_HI_HI is the largest 5-bit offset, so only the lower bound is compared
   function automatic logic is_readable(input logic [OFF_W-1:0] off);
      return (off == RD_LO0) || (off == RD_LO1) || (off >= RD_HI_LO);
   endfunction

   // Result block is read-only when write protection is built in
   function automatic logic is_result_reg(input logic [OFF_W-1:0] off);
      return (off >= RD_HI_LO);
   endfunction

endpackage

// File: rtl/mac_addr_decode.sv
// Combinational window check and access permission decode for the register bridge.
// Optional feature macro: REG_WR_PROTECT_EN (rejects writes to result offsets 0x12..0x1F).
module mac_addr_decode
   import mac_reg_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   output logic              in_window,
   output logic [OFF_W-1:0]  offset,
   output logic              rd_ok,
   output logic              wr_ok
);

   // Full 32-bit compare so addresses near the top of the space cannot wrap into the window
   always_comb begin
      in_window = (addr >= BASE_ADDR) && (addr <= LAST_ADDR);
      offset    = OFF_W'(addr - BASE_ADDR);
      rd_ok     = in_window && !we && is_readable(offset);
`ifdef REG_WR_PROTECT_EN
      wr_ok     = in_window && we && !is_result_reg(offset);
`else
      wr_ok     = in_window && we;
`endif
   end

endmodule

// File: rtl/mac_reg_bus_bridge.sv
// Host-to-register-file bridge: IDLE -> EXEC -> RESP, ack two cycles after request acceptance.
// Optional feature macro: REG_WR_PROTECT_EN (write protection of result offsets, see mac_addr_decode).
module mac_reg_bus_bridge
   import mac_reg_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_busy,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_err,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic [ADDR_W-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data
);

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              ack_q, ack_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              rf_write_q, rf_write_d;
   logic [ADDR_W-1:0] rf_wr_addr_q, rf_wr_addr_d;
   logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
   logic [ADDR_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
   logic              rd_ok_q, rd_ok_d;
   logic              err_pend_q, err_pend_d;

   logic              dec_in_window;
   logic [OFF_W-1:0]  dec_offset;
   logic              dec_rd_ok;
   logic              dec_wr_ok;

   // Decode the request at acceptance so the register-file strobes are registered into EXEC
   mac_addr_decode u_decode (
      .addr      (host_addr),
      .we        (host_we),
      .in_window (dec_in_window),
      .offset    (dec_offset),
      .rd_ok     (dec_rd_ok),
      .wr_ok     (dec_wr_ok)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      ack_d        = 1'b0;
      rdata_d      = '0;
      err_d        = 1'b0;
      rf_write_d   = 1'b0;
      rf_wr_addr_d = rf_wr_addr_q;
      rf_wr_data_d = rf_wr_data_q;
      rf_rd_addr_d = rf_rd_addr_q;
      rd_ok_d      = rd_ok_q;
      err_pend_d   = err_pend_q;

      case (state_q)
         IDLE: begin
            if (host_req) begin
               state_d    = EXEC;
               busy_d     = 1'b1;
               rd_ok_d    = dec_rd_ok;
               err_pend_d = host_we ? !dec_wr_ok : !dec_rd_ok;
               if (dec_wr_ok) begin
                  rf_write_d   = 1'b1;
                  rf_wr_addr_d = ADDR_W'(dec_offset);
                  rf_wr_data_d = host_wdata;
               end
               if (!host_we && dec_in_window) begin
                  rf_rd_addr_d = ADDR_W'(dec_offset);
               end
            end
         end
         EXEC: begin
            state_d = RESP;
            ack_d   = 1'b1;
            err_d   = err_pend_q;
            rdata_d = rd_ok_q ? rf_rd_data : '0;
         end
         RESP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         ack_q        <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         rf_write_q   <= 1'b0;
         rf_wr_addr_q <= '0;
         rf_wr_data_q <= '0;
         rf_rd_addr_q <= '0;
         rd_ok_q      <= 1'b0;
         err_pend_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         ack_q        <= ack_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         rf_write_q   <= rf_write_d;
         rf_wr_addr_q <= rf_wr_addr_d;
         rf_wr_data_q <= rf_wr_data_d;
         rf_rd_addr_q <= rf_rd_addr_d;
         rd_ok_q      <= rd_ok_d;
         err_pend_q   <= err_pend_d;
      end
   end

   assign host_busy  = busy_q;
   assign host_ack   = ack_q;
   assign host_rdata = rdata_q;
   assign host_err   = err_q;
   assign rf_write   = rf_write_q;
   assign rf_wr_addr = rf_wr_addr_q;
   assign rf_wr_data = rf_wr_data_q;
   assign rf_rd_addr = rf_rd_addr_q;

endmodule
